// File: rtl/hsv_class_pipe.sv
// hsv_class_pipe
// Two-stage pipelined HSV pixel classifier with a runtime-programmable
// threshold table and per-frame class histograms.
//
// Ports:
//   clk_in          system clock
//   rst_in          asynchronous, active-high reset
//   cfg_we          table write strobe
//   cfg_idx         table entry to write (writes to idx >= NUM_CLASSES ignored)
//   cfg_wdata       {en, code, hmin, hmax, smin, vmin}
//   pix_valid_in    pixel strobe
//   pix_eof_in      last pixel of frame, qualified by pix_valid_in
//   h_in/s_in/v_in  pixel HSV components
//   cls_valid_out   classified pixel strobe (2 cycles after pix_valid_in)
//   cls_out         class code of the winning entry, DEFAULT_CLS if none
//   cls_idx_out     winning entry index, NUM_CLASSES if none
//   stats_valid_out one-cycle pulse when stats_out is refreshed
//   stats_out       per-entry counts; slice i = entry i, top slice = no match
module hsv_class_pipe #(
  parameter int                WIDTH       = 8,
  parameter int                NUM_CLASSES = 4,
  parameter int                CLS_W       = 3,
  parameter logic [CLS_W-1:0]  DEFAULT_CLS = 3'b111,
  parameter int                CNT_W       = 20,
  localparam int               IDX_W       = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  localparam int               OIDX_W      = $clog2(NUM_CLASSES + 1),
  localparam int               ENTRY_W     = 1 + CLS_W + 4 * WIDTH,
  localparam int               STATS_W     = (NUM_CLASSES + 1) * CNT_W
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                cfg_we,
  input  logic [IDX_W-1:0]    cfg_idx,
  input  logic [ENTRY_W-1:0]  cfg_wdata,
  input  logic                pix_valid_in,
  input  logic                pix_eof_in,
  input  logic [WIDTH-1:0]    h_in,
  input  logic [WIDTH-1:0]    s_in,
  input  logic [WIDTH-1:0]    v_in,
  output logic                cls_valid_out,
  output logic [CLS_W-1:0]    cls_out,
  output logic [OIDX_W-1:0]   cls_idx_out,
  output logic                stats_valid_out,
  output logic [STATS_W-1:0]  stats_out
);

  // Power-up contents of the threshold table; entries 4 and above start disabled.
  function automatic logic [ENTRY_W-1:0] reset_entry(input int i);
    logic [ENTRY_W-1:0] e;
    case (i)
      0:       e = {1'b1, CLS_W'(1), WIDTH'(0),  WIDTH'(3),  WIDTH'(50),  WIDTH'(50)};
      1:       e = {1'b1, CLS_W'(4), WIDTH'(4),  WIDTH'(9),  WIDTH'(100), WIDTH'(100)};
      2:       e = {1'b1, CLS_W'(2), WIDTH'(21), WIDTH'(32), WIDTH'(100), WIDTH'(100)};
      3:       e = {1'b1, CLS_W'(3), WIDTH'(0),  WIDTH'(32), WIDTH'(100), WIDTH'(100)};
      default: e = '0;
    endcase
    return e;
  endfunction

  logic [ENTRY_W-1:0]  tbl        [NUM_CLASSES];
  logic [CLS_W-1:0]    entry_code [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] match;

  logic                s1_valid;
  logic                s1_eof;
  logic [NUM_CLASSES-1:0] s1_match;
  logic [CLS_W-1:0]    s1_code    [NUM_CLASSES];

  logic [OIDX_W-1:0]   enc_idx;
  logic [CLS_W-1:0]    enc_code;

  logic [CNT_W-1:0]    cnt        [NUM_CLASSES + 1];
  logic [CNT_W-1:0]    cnt_inc    [NUM_CLASSES + 1];
  logic [STATS_W-1:0]  stats_next;

  // Threshold table. A write lands at the clock edge, so a pixel sampled on
  // that same edge still sees the old entry.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_CLASSES; i++) tbl[i] <= reset_entry(i);
    end else if (cfg_we) begin
      for (int i = 0; i < NUM_CLASSES; i++)
        if (cfg_idx == IDX_W'(i)) tbl[i] <= cfg_wdata;
    end
  end

  // Per-entry match. A range with hmin > hmax wraps through zero (red hues).
  for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_entry
    logic             en;
    logic [WIDTH-1:0] hmin, hmax, smin, vmin;
    logic             hue_ok;
    assign en            = tbl[g][ENTRY_W-1];
    assign entry_code[g] = tbl[g][ENTRY_W-2 -: CLS_W];
    assign hmin          = tbl[g][4*WIDTH-1 -: WIDTH];
    assign hmax          = tbl[g][3*WIDTH-1 -: WIDTH];
    assign smin          = tbl[g][2*WIDTH-1 -: WIDTH];
    assign vmin          = tbl[g][WIDTH-1:0];
    assign hue_ok        = (hmin <= hmax) ? ((h_in >= hmin) && (h_in <= hmax))
                                          : ((h_in >= hmin) || (h_in <= hmax));
    assign match[g]      = en && hue_ok && (s_in > smin) && (v_in > vmin);
  end

  // Stage 1: match vector plus a snapshot of the entry codes, so a table
  // rewrite while the pixel sits in stage 1 cannot change its class.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
      s1_match <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) s1_code[i] <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      s1_eof   <= pix_valid_in && pix_eof_in;
      s1_match <= match;
      for (int i = 0; i < NUM_CLASSES; i++) s1_code[i] <= entry_code[i];
    end
  end

  // Lowest matching index wins.
  always_comb begin
    enc_idx  = OIDX_W'(NUM_CLASSES);
    enc_code = DEFAULT_CLS;
    for (int i = NUM_CLASSES - 1; i >= 0; i--) begin
      if (s1_match[i]) begin
        enc_idx  = OIDX_W'(i);
        enc_code = s1_code[i];
      end
    end
  end

  // Counters are bumped on the same edge that presents the pixel on
  // cls_valid_out, so an EOF snapshot can include its own pixel.
  always_comb begin
    stats_next = '0;
    for (int i = 0; i <= NUM_CLASSES; i++) begin
      cnt_inc[i] = cnt[i];
      if (s1_valid && (enc_idx == OIDX_W'(i)) && (cnt[i] != {CNT_W{1'b1}}))
        cnt_inc[i] = cnt[i] + CNT_W'(1);
      stats_next[i*CNT_W +: CNT_W] = cnt_inc[i];
    end
  end

  // Stage 2: classification outputs, histogram counters and the EOF snapshot.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cls_valid_out   <= 1'b0;
      cls_out         <= DEFAULT_CLS;
      cls_idx_out     <= OIDX_W'(NUM_CLASSES);
      stats_valid_out <= 1'b0;
      stats_out       <= '0;
      for (int i = 0; i <= NUM_CLASSES; i++) cnt[i] <= '0;
    end else begin
      cls_valid_out   <= s1_valid;
      stats_valid_out <= s1_valid && s1_eof;
      if (s1_valid) begin
        cls_out     <= enc_code;
        cls_idx_out <= enc_idx;
      end
      if (s1_valid && s1_eof) begin
        stats_out <= stats_next;
        for (int i = 0; i <= NUM_CLASSES; i++) cnt[i] <= '0;
      end else begin
        for (int i = 0; i <= NUM_CLASSES; i++) cnt[i] <= cnt_inc[i];
      end
    end
  end

endmodule

// File: tb/tb_hsv_class_pipe.sv
// tb_hsv_class_pipe
// Directed bench for hsv_class_pipe. Two instances share stimulus: the
// default build (CNT_W=20) and a CNT_W=3 build for counter saturation.
module tb_hsv_class_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [35:0] cfg_wdata;
  logic        pix_valid;
  logic        pix_eof;
  logic [7:0]  h, s, v;

  logic        cls_valid, cls_valid2;
  logic [2:0]  cls, cls2;
  logic [2:0]  cls_idx, cls_idx2;
  logic        stats_valid, stats_valid2;
  logic [99:0] stats;
  logic [14:0] stats2;

  always #5 clk = ~clk;

  hsv_class_pipe dut (
    .clk_in(clk), .rst_in(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .pix_valid_in(pix_valid), .pix_eof_in(pix_eof),
    .h_in(h), .s_in(s), .v_in(v),
    .cls_valid_out(cls_valid), .cls_out(cls), .cls_idx_out(cls_idx),
    .stats_valid_out(stats_valid), .stats_out(stats)
  );

  hsv_class_pipe #(.CNT_W(3)) dut_sat (
    .clk_in(clk), .rst_in(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_wdata(cfg_wdata), .pix_valid_in(pix_valid), .pix_eof_in(pix_eof),
    .h_in(h), .s_in(s), .v_in(v),
    .cls_valid_out(cls_valid2), .cls_out(cls2), .cls_idx_out(cls_idx2),
    .stats_valid_out(stats_valid2), .stats_out(stats2)
  );

  typedef struct {
    logic [7:0] h;
    logic [7:0] s;
    logic [7:0] v;
    logic       eof;
    logic [2:0] cls;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs [80];
  int   nv = 0;

  int checks = 0;
  int errors = 0;

  // Histogram reference for both instances, cleared at EOF and on reset.
  int unsigned m1 [5];
  int unsigned m2 [5];

  function automatic void addVec(input logic [7:0] hh, ss, vv, input logic e,
                                 input logic [2:0] c, ix);
    vecs[nv].h   = hh;
    vecs[nv].s   = ss;
    vecs[nv].v   = vv;
    vecs[nv].eof = e;
    vecs[nv].cls = c;
    vecs[nv].idx = ix;
    nv++;
  endfunction

  function automatic void clearModel();
    for (int k = 0; k < 5; k++) begin
      m1[k] = 0;
      m2[k] = 0;
    end
  endfunction

  function automatic logic [99:0] pack1();
    logic [99:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[k*20 +: 20] = m1[k][19:0];
    return r;
  endfunction

  function automatic logic [14:0] pack2();
    logic [14:0] r;
    r = '0;
    for (int k = 0; k < 5; k++) r[k*3 +: 3] = m2[k][2:0];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Streams vecs[first .. first+count-1] back to back and checks each result
  // two cycles later; optionally a table write accompanies the first pixel.
  task automatic applyStimulus(input int first, input int count, input bit do_cfg,
                               input logic [1:0] ci, input logic [35:0] cd);
    for (int cyc = 0; cyc <= count + 1; cyc++) begin
      if (cyc < count) begin
        pix_valid = 1'b1;
        pix_eof   = vecs[first+cyc].eof;
        h         = vecs[first+cyc].h;
        s         = vecs[first+cyc].s;
        v         = vecs[first+cyc].v;
        if (do_cfg && cyc == 0) begin
          cfg_we    = 1'b1;
          cfg_idx   = ci;
          cfg_wdata = cd;
        end
      end else begin
        pix_valid = 1'b0;
        pix_eof   = 1'b0;
      end
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      if (cyc >= 1) begin
        int j;
        j = cyc - 1;
        if (j < count) begin
          vec_t e;
          e = vecs[first+j];
          checkOutput($sformatf("cls_valid[%0d]", first+j), cls_valid, 1);
          checkOutput($sformatf("cls[%0d]", first+j), cls, e.cls);
          checkOutput($sformatf("cls_idx[%0d]", first+j), cls_idx, e.idx);
          checkOutput($sformatf("cls_sat[%0d]", first+j), cls2, e.cls);
          if (m1[e.idx] < 32'hFFFFF) m1[e.idx]++;
          if (m2[e.idx] < 7) m2[e.idx]++;
          checkOutput($sformatf("stats_valid[%0d]", first+j), stats_valid, e.eof);
          checkOutput($sformatf("stats_valid_sat[%0d]", first+j), stats_valid2, e.eof);
          if (e.eof) begin
            checkOutput($sformatf("stats[%0d]", first+j), stats, pack1());
            checkOutput($sformatf("stats_sat[%0d]", first+j), stats2, pack2());
            clearModel();
          end
        end else begin
          checkOutput("idle_cls_valid", cls_valid, 0);
          checkOutput("idle_stats_valid", stats_valid, 0);
        end
      end
    end
  endtask

  task automatic cfgWrite(input logic [1:0] ci, input logic [35:0] cd);
    cfg_we    = 1'b1;
    cfg_idx   = ci;
    cfg_wdata = cd;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic resetDut(input string tag);
    rst       = 1'b1;
    pix_valid = 1'b0;
    pix_eof   = 1'b0;
    cfg_we    = 1'b0;
    #2;
    checkOutput({tag, "_cls_valid"}, cls_valid, 0);
    checkOutput({tag, "_cls"}, cls, 3'b111);
    checkOutput({tag, "_cls_idx"}, cls_idx, 3'd4);
    checkOutput({tag, "_stats_valid"}, stats_valid, 0);
    checkOutput({tag, "_stats"}, stats, 0);
    checkOutput({tag, "_stats_sat"}, stats2, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearModel();
  endtask

  int segA, segB, segC, segD, segE, segF, segG, segH;
  logic [99:0] exp_stats;
  logic [14:0] exp_stats2;

  initial begin
    // Segment A: default table, priority, strict thresholds, hue bounds.
    segA = nv;
    addVec(8'd2,   8'd60,  8'd60,  0, 3'b001, 3'd0);
    addVec(8'd25,  8'd150, 8'd150, 0, 3'b010, 3'd2);
    addVec(8'd25,  8'd90,  8'd150, 0, 3'b111, 3'd4);
    addVec(8'd5,   8'd101, 8'd101, 0, 3'b100, 3'd1);
    addVec(8'd2,   8'd150, 8'd150, 0, 3'b001, 3'd0);
    addVec(8'd15,  8'd150, 8'd150, 0, 3'b011, 3'd3);
    addVec(8'd2,   8'd50,  8'd60,  0, 3'b111, 3'd4);
    addVec(8'd33,  8'd200, 8'd200, 0, 3'b111, 3'd4);
    addVec(8'd32,  8'd101, 8'd101, 0, 3'b010, 3'd2);
    addVec(8'd0,   8'd51,  8'd51,  0, 3'b001, 3'd0);
    addVec(8'd4,   8'd100, 8'd200, 0, 3'b111, 3'd4);
    addVec(8'd9,   8'd101, 8'd101, 0, 3'b100, 3'd1);
    addVec(8'd10,  8'd101, 8'd101, 1, 3'b011, 3'd3);
    // Segment B: e1 rewritten as wrapping hue 250..5 with zero s/v minimums.
    segB = nv;
    addVec(8'd252, 8'd1,   8'd1,   0, 3'b101, 3'd1);
    addVec(8'd6,   8'd1,   8'd1,   0, 3'b111, 3'd4);
    addVec(8'd250, 8'd1,   8'd1,   0, 3'b101, 3'd1);
    addVec(8'd249, 8'd1,   8'd1,   0, 3'b111, 3'd4);
    addVec(8'd5,   8'd1,   8'd1,   0, 3'b101, 3'd1);
    addVec(8'd2,   8'd60,  8'd60,  0, 3'b001, 3'd0);
    // Segment C: e0 code changes alongside the first pixel.
    segC = nv;
    addVec(8'd2,   8'd60,  8'd60,  0, 3'b001, 3'd0);
    addVec(8'd2,   8'd60,  8'd60,  1, 3'b110, 3'd0);
    // Segment D: 10-pixel frame, 3 e0, 2 e2, 5 none.
    segD = nv;
    for (int i = 0; i < 3; i++) addVec(8'd2, 8'd60, 8'd60, 0, 3'b001, 3'd0);
    for (int i = 0; i < 2; i++) addVec(8'd25, 8'd150, 8'd150, 0, 3'b010, 3'd2);
    for (int i = 0; i < 5; i++) addVec(8'd100, 8'd10, 8'd10, (i == 4), 3'b111, 3'd4);
    // Segment E: next frame counted from zero.
    segE = nv;
    addVec(8'd15,  8'd150, 8'd150, 0, 3'b011, 3'd3);
    addVec(8'd15,  8'd150, 8'd150, 1, 3'b011, 3'd3);
    // Segment F: back-to-back EOF pixels.
    segF = nv;
    addVec(8'd2,   8'd60,  8'd60,  1, 3'b001, 3'd0);
    addVec(8'd25,  8'd150, 8'd150, 1, 3'b010, 3'd2);
    // Segment G: 9 e0 pixels, saturates the CNT_W=3 instance.
    segG = nv;
    for (int i = 0; i < 9; i++) addVec(8'd2, 8'd60, 8'd60, (i == 8), 3'b001, 3'd0);
    // Segment H: first frame after a mid-frame reset.
    segH = nv;
    addVec(8'd2,   8'd60,  8'd60,  0, 3'b001, 3'd0);
    addVec(8'd100, 8'd10,  8'd10,  1, 3'b111, 3'd4);

    cfg_idx   = '0;
    cfg_wdata = '0;
    h = '0;
    s = '0;
    v = '0;
    clearModel();
    resetDut("reset");

    applyStimulus(segA, segB - segA, 0, 2'd0, 36'd0);

    cfgWrite(2'd1, {1'b1, 3'b101, 8'd250, 8'd5, 8'd0, 8'd0});
    applyStimulus(segB, segC - segB, 0, 2'd0, 36'd0);

    applyStimulus(segC, segD - segC, 1, 2'd0, {1'b1, 3'b110, 8'd0, 8'd3, 8'd50, 8'd50});

    resetDut("reset2");
    applyStimulus(segD, segE - segD, 0, 2'd0, 36'd0);
    exp_stats = {20'd5, 20'd0, 20'd2, 20'd0, 20'd3};
    checkOutput("hist_frame", stats, exp_stats);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("hist_hold", stats, exp_stats);
    checkOutput("hist_no_pulse", stats_valid, 0);

    applyStimulus(segE, segF - segE, 0, 2'd0, 36'd0);
    exp_stats = {20'd0, 20'd2, 20'd0, 20'd0, 20'd0};
    checkOutput("hist_next_frame", stats, exp_stats);

    applyStimulus(segF, segG - segF, 0, 2'd0, 36'd0);
    exp_stats = {20'd0, 20'd0, 20'd1, 20'd0, 20'd0};
    checkOutput("hist_b2b_eof", stats, exp_stats);

    applyStimulus(segG, segH - segG, 0, 2'd0, 36'd0);
    exp_stats  = {20'd0, 20'd0, 20'd0, 20'd0, 20'd9};
    exp_stats2 = {3'd0, 3'd0, 3'd0, 3'd0, 3'd7};
    checkOutput("hist_nine", stats, exp_stats);
    checkOutput("hist_saturate", stats2, exp_stats2);

    // Reset while four pixels are in flight after e0 was recoded.
    cfgWrite(2'd0, {1'b1, 3'b110, 8'd0, 8'd3, 8'd50, 8'd50});
    for (int i = 0; i < 4; i++) begin
      pix_valid = 1'b1;
      pix_eof   = 1'b0;
      h = 8'd2;
      s = 8'd60;
      v = 8'd60;
      @(posedge clk);
      #1;
    end
    resetDut("midreset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("midreset_cls_valid", cls_valid, 0);
      checkOutput("midreset_stats_valid", stats_valid, 0);
    end
    applyStimulus(segH, nv - segH, 0, 2'd0, 36'd0);
    exp_stats = {20'd1, 20'd0, 20'd0, 20'd0, 20'd1};
    checkOutput("midreset_hist", stats, exp_stats);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
